// File: rtl/aludec_pipe_pkg.sv
// Opcode/funct codes, alucontrol encodings and HI/LO scoreboard
// types shared by the registered ALU decoder.
package aludec_pipe_pkg;

   localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
   localparam logic [5:0] EXE_REGIMM_INST  = 6'b000001;
   localparam logic [5:0] EXE_COP0_INST    = 6'b010000;
   localparam logic [5:0] EXE_J     = 6'b000010;
   localparam logic [5:0] EXE_JAL   = 6'b000011;
   localparam logic [5:0] EXE_BEQ   = 6'b000100;
   localparam logic [5:0] EXE_BNE   = 6'b000101;
   localparam logic [5:0] EXE_BLEZ  = 6'b000110;
   localparam logic [5:0] EXE_BGTZ  = 6'b000111;
   localparam logic [5:0] EXE_ADDI  = 6'b001000;
   localparam logic [5:0] EXE_ADDIU = 6'b001001;
   localparam logic [5:0] EXE_SLTI  = 6'b001010;
   localparam logic [5:0] EXE_SLTIU = 6'b001011;
   localparam logic [5:0] EXE_ANDI  = 6'b001100;
   localparam logic [5:0] EXE_ORI   = 6'b001101;
   localparam logic [5:0] EXE_XORI  = 6'b001110;
   localparam logic [5:0] EXE_LUI   = 6'b001111;
   localparam logic [5:0] EXE_LB    = 6'b100000;
   localparam logic [5:0] EXE_LH    = 6'b100001;
   localparam logic [5:0] EXE_LW    = 6'b100011;
   localparam logic [5:0] EXE_LBU   = 6'b100100;
   localparam logic [5:0] EXE_LHU   = 6'b100101;
   localparam logic [5:0] EXE_SB    = 6'b101000;
   localparam logic [5:0] EXE_SH    = 6'b101001;
   localparam logic [5:0] EXE_SW    = 6'b101011;

   localparam logic [5:0] EXE_SLL     = 6'b000000;
   localparam logic [5:0] EXE_SRL     = 6'b000010;
   localparam logic [5:0] EXE_SRA     = 6'b000011;
   localparam logic [5:0] EXE_SLLV    = 6'b000100;
   localparam logic [5:0] EXE_SRLV    = 6'b000110;
   localparam logic [5:0] EXE_SRAV    = 6'b000111;
   localparam logic [5:0] EXE_JR      = 6'b001000;
   localparam logic [5:0] EXE_JALR    = 6'b001001;
   localparam logic [5:0] EXE_SYSCALL = 6'b001100;
   localparam logic [5:0] EXE_BREAK   = 6'b001101;
   localparam logic [5:0] EXE_MFHI    = 6'b010000;
   localparam logic [5:0] EXE_MTHI    = 6'b010001;
   localparam logic [5:0] EXE_MFLO    = 6'b010010;
   localparam logic [5:0] EXE_MTLO    = 6'b010011;
   localparam logic [5:0] EXE_MULT    = 6'b011000;
   localparam logic [5:0] EXE_MULTU   = 6'b011001;
   localparam logic [5:0] EXE_DIV     = 6'b011010;
   localparam logic [5:0] EXE_DIVU    = 6'b011011;
   localparam logic [5:0] EXE_ADD     = 6'b100000;
   localparam logic [5:0] EXE_ADDU    = 6'b100001;
   localparam logic [5:0] EXE_SUB     = 6'b100010;
   localparam logic [5:0] EXE_SUBU    = 6'b100011;
   localparam logic [5:0] EXE_AND     = 6'b100100;
   localparam logic [5:0] EXE_OR      = 6'b100101;
   localparam logic [5:0] EXE_XOR     = 6'b100110;
   localparam logic [5:0] EXE_NOR     = 6'b100111;
   localparam logic [5:0] EXE_SLT     = 6'b101010;
   localparam logic [5:0] EXE_SLTU    = 6'b101011;
   localparam logic [5:0] EXE_ERET    = 6'b011000;

   localparam logic [4:0] EXE_MF_RS = 5'b00000;
   localparam logic [4:0] EXE_MT_RS = 5'b00100;
   localparam logic [4:0] EXE_CO_RS = 5'b10000;

   localparam logic [7:0] EXE_NOP_OP     = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP     = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP      = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP     = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP     = 8'b00100111;
   localparam logic [7:0] EXE_ANDI_OP    = 8'b01011001;
   localparam logic [7:0] EXE_ORI_OP     = 8'b01011010;
   localparam logic [7:0] EXE_XORI_OP    = 8'b01011011;
   localparam logic [7:0] EXE_LUI_OP     = 8'b01011100;
   localparam logic [7:0] EXE_SLL_OP     = 8'b01111100;
   localparam logic [7:0] EXE_SLLV_OP    = 8'b00000100;
   localparam logic [7:0] EXE_SRL_OP     = 8'b00000010;
   localparam logic [7:0] EXE_SRLV_OP    = 8'b00000110;
   localparam logic [7:0] EXE_SRA_OP     = 8'b00000011;
   localparam logic [7:0] EXE_SRAV_OP    = 8'b00000111;
   localparam logic [7:0] EXE_MFHI_OP    = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP    = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP    = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP    = 8'b00010011;
   localparam logic [7:0] EXE_SLT_OP     = 8'b00101010;
   localparam logic [7:0] EXE_SLTU_OP    = 8'b00101011;
   localparam logic [7:0] EXE_SLTI_OP    = 8'b01010111;
   localparam logic [7:0] EXE_SLTIU_OP   = 8'b01011000;
   localparam logic [7:0] EXE_ADD_OP     = 8'b00100000;
   localparam logic [7:0] EXE_ADDU_OP    = 8'b00100001;
   localparam logic [7:0] EXE_SUB_OP     = 8'b00100010;
   localparam logic [7:0] EXE_SUBU_OP    = 8'b00100011;
   localparam logic [7:0] EXE_ADDI_OP    = 8'b01010101;
   localparam logic [7:0] EXE_ADDIU_OP   = 8'b01010110;
   localparam logic [7:0] EXE_MULT_OP    = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP   = 8'b00011001;
   localparam logic [7:0] EXE_DIV_OP     = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP    = 8'b00011011;
   localparam logic [7:0] EXE_JR_OP      = 8'b00001000;
   localparam logic [7:0] EXE_JALR_OP    = 8'b00001001;
   localparam logic [7:0] EXE_SYSCALL_OP = 8'b00001100;
   localparam logic [7:0] EXE_BREAK_OP   = 8'b00001011;
   localparam logic [7:0] EXE_LB_OP      = 8'b11100000;
   localparam logic [7:0] EXE_LBU_OP     = 8'b11100100;
   localparam logic [7:0] EXE_LH_OP      = 8'b11100001;
   localparam logic [7:0] EXE_LHU_OP     = 8'b11100101;
   localparam logic [7:0] EXE_LW_OP      = 8'b11100011;
   localparam logic [7:0] EXE_SB_OP      = 8'b11101000;
   localparam logic [7:0] EXE_SH_OP      = 8'b11101001;
   localparam logic [7:0] EXE_SW_OP      = 8'b11101011;
   localparam logic [7:0] EXE_MFC0_OP    = 8'b01011101;
   localparam logic [7:0] EXE_MTC0_OP    = 8'b01100000;
   localparam logic [7:0] EXE_ERET_OP    = 8'b01101011;

   typedef enum logic [1:0] {
      SB_IDLE     = 2'd0,
      SB_BUSY_MUL = 2'd1,
      SB_BUSY_DIV = 2'd2
   } sb_state_e;

   typedef struct packed {
      logic [7:0] aluop;
      logic       ri;
      logic       hilo;
      logic       mul;
      logic       div;
   } dec_t;

endpackage

// File: rtl/aludec_pipe_comb.sv
// Pure combinational MIPS op/funct decode into alucontrol, ri and
// HI/LO hazard flags. COP0 decode is enabled by ALUDEC_CP0_EN.
module aludec_pipe_comb
   import aludec_pipe_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic [4:0] rs,
   output dec_t       dec
);

   logic [7:0] sp_op;
   logic       sp_ri;
   logic       sp_hilo;
   logic       sp_mul;
   logic       sp_div;

   always_comb begin
      sp_op   = EXE_NOP_OP;
      sp_ri   = 1'b0;
      sp_hilo = 1'b0;
      sp_mul  = 1'b0;
      sp_div  = 1'b0;
      unique case (funct)
         EXE_AND:     sp_op = EXE_AND_OP;
         EXE_OR:      sp_op = EXE_OR_OP;
         EXE_XOR:     sp_op = EXE_XOR_OP;
         EXE_NOR:     sp_op = EXE_NOR_OP;
         EXE_SLL:     sp_op = EXE_SLL_OP;
         EXE_SRL:     sp_op = EXE_SRL_OP;
         EXE_SRA:     sp_op = EXE_SRA_OP;
         EXE_SLLV:    sp_op = EXE_SLLV_OP;
         EXE_SRLV:    sp_op = EXE_SRLV_OP;
         EXE_SRAV:    sp_op = EXE_SRAV_OP;
         EXE_ADD:     sp_op = EXE_ADD_OP;
         EXE_ADDU:    sp_op = EXE_ADDU_OP;
         EXE_SUB:     sp_op = EXE_SUB_OP;
         EXE_SUBU:    sp_op = EXE_SUBU_OP;
         EXE_SLT:     sp_op = EXE_SLT_OP;
         EXE_SLTU:    sp_op = EXE_SLTU_OP;
         EXE_JR:      sp_op = EXE_JR_OP;
         EXE_JALR:    sp_op = EXE_JALR_OP;
         EXE_SYSCALL: sp_op = EXE_SYSCALL_OP;
         EXE_BREAK:   sp_op = EXE_BREAK_OP;
         EXE_MFHI: begin
            sp_op   = EXE_MFHI_OP;
            sp_hilo = 1'b1;
         end
         EXE_MTHI: begin
            sp_op   = EXE_MTHI_OP;
            sp_hilo = 1'b1;
         end
         EXE_MFLO: begin
            sp_op   = EXE_MFLO_OP;
            sp_hilo = 1'b1;
         end
         EXE_MTLO: begin
            sp_op   = EXE_MTLO_OP;
            sp_hilo = 1'b1;
         end
         EXE_MULT, EXE_MULTU: begin
            sp_op   = funct[0] ? EXE_MULTU_OP : EXE_MULT_OP;
            sp_hilo = 1'b1;
            sp_mul  = 1'b1;
         end
         EXE_DIV, EXE_DIVU: begin
            sp_op   = funct[0] ? EXE_DIVU_OP : EXE_DIV_OP;
            sp_hilo = 1'b1;
            sp_div  = 1'b1;
         end
         default: sp_ri = 1'b1;
      endcase
   end

   always_comb begin
      dec       = '0;
      dec.aluop = EXE_NOP_OP;
      unique case (op)
         EXE_SPECIAL_INST: begin
            dec.aluop = sp_op;
            dec.ri    = sp_ri;
            dec.hilo  = sp_hilo;
            dec.mul   = sp_mul;
            dec.div   = sp_div;
         end
         EXE_ANDI:  dec.aluop = EXE_ANDI_OP;
         EXE_ORI:   dec.aluop = EXE_ORI_OP;
         EXE_XORI:  dec.aluop = EXE_XORI_OP;
         EXE_LUI:   dec.aluop = EXE_LUI_OP;
         EXE_ADDI:  dec.aluop = EXE_ADDI_OP;
         EXE_ADDIU: dec.aluop = EXE_ADDIU_OP;
         EXE_SLTI:  dec.aluop = EXE_SLTI_OP;
         EXE_SLTIU: dec.aluop = EXE_SLTIU_OP;
         EXE_LB:    dec.aluop = EXE_LB_OP;
         EXE_LBU:   dec.aluop = EXE_LBU_OP;
         EXE_LH:    dec.aluop = EXE_LH_OP;
         EXE_LHU:   dec.aluop = EXE_LHU_OP;
         EXE_LW:    dec.aluop = EXE_LW_OP;
         EXE_SB:    dec.aluop = EXE_SB_OP;
         EXE_SH:    dec.aluop = EXE_SH_OP;
         EXE_SW:    dec.aluop = EXE_SW_OP;
         EXE_J, EXE_JAL, EXE_BEQ, EXE_BNE,
         EXE_BGTZ, EXE_BLEZ, EXE_REGIMM_INST: begin
            dec.ri = 1'b0;
         end
`ifdef ALUDEC_CP0_EN
         EXE_COP0_INST: begin
            if (rs == EXE_MT_RS) begin
               dec.aluop = EXE_MTC0_OP;
            end else if (rs == EXE_MF_RS) begin
               dec.aluop = EXE_MFC0_OP;
            end else if (rs == EXE_CO_RS && funct == EXE_ERET) begin
               // ERET serialises against an in-flight MULT/DIV
               dec.aluop = EXE_ERET_OP;
               dec.hilo  = 1'b1;
            end else begin
               dec.ri = 1'b1;
            end
         end
`endif
         default: dec.ri = 1'b1;
      endcase
   end

`ifndef ALUDEC_CP0_EN
   logic unused_rs;
   assign unused_rs = ^rs;
`endif

endmodule

// File: rtl/aludec_pipe.sv
// Registered ID/EX alucontrol stage with valid/ready, optional skid
// entry and HI/LO scoreboard. COP0 decode enabled by ALUDEC_CP0_EN.
module aludec_pipe
   import aludec_pipe_pkg::*;
#(
   parameter int ALUOP_W    = 8,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 36,
   parameter int SKID_EN    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic [4:0]         rs,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ALUOP_W-1:0] alucontrol,
   output logic               ri,
   output logic               hilo_busy
);

   dec_t       dec;
   logic [8:0] in_ent;
   logic [8:0] out_q, out_d, skid_q, skid_d;
   logic       out_valid_q, out_valid_d;
   logic       skid_valid_q, skid_valid_d;
   logic       can_load, accept, out_fire;
   sb_state_e  state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   aludec_pipe_comb u_dec (
      .op    (op),
      .funct (funct),
      .rs    (rs),
      .dec   (dec)
   );

   assign in_ent   = {dec.ri, dec.aluop};
   assign out_fire = out_valid_q && out_ready;
   // with the skid entry, ready depends only on registered state
   assign can_load = (SKID_EN != 0) ? !skid_valid_q
                                    : (!out_valid_q || out_ready);
   assign in_ready = !rst && !flush && can_load
                     && !(hilo_busy && dec.hilo);
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_fire) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = accept;
            if (accept) skid_d = in_ent;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = in_ent;
         end
      end else if (accept) begin
         skid_d       = in_ent;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SB_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SB_IDLE: begin
            if (accept && dec.mul && MUL_CYCLES != 0) begin
               state_d = SB_BUSY_MUL;
               cnt_d   = 6'(MUL_CYCLES);
            end else if (accept && dec.div && DIV_CYCLES != 0) begin
               state_d = SB_BUSY_DIV;
               cnt_d   = 6'(DIV_CYCLES);
            end
         end
         SB_BUSY_MUL, SB_BUSY_DIV: begin
            if (cnt_q == 6'd1) begin
               state_d = SB_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: begin
            state_d = SB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      hilo_busy = (state_q != SB_IDLE);
   end

   assign out_valid  = out_valid_q;
   assign alucontrol = ALUOP_W'(out_q[7:0]);
   assign ri         = out_q[8];

endmodule

// File: tb/tb_aludec_pipe.sv
// Randomised scoreboard bench for aludec_pipe against a table-driven
// reference decoder and a cycle-count model of HI/LO occupancy.
module tb_aludec_pipe;

   localparam int ALUOP_W = 8;
   localparam int MUL_CYC = 2;
   localparam int DIV_CYC = 36;
   localparam int SKID    = 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               flush = 1'b0;
   logic               out_ready = 1'b0;
   logic [5:0]         op = '0;
   logic [5:0]         funct = '0;
   logic [4:0]         rs = '0;
   logic               in_ready, out_valid, ri, hilo_busy;
   logic [ALUOP_W-1:0] alucontrol;

   always #5 clk = ~clk;

   aludec_pipe #(
      .ALUOP_W    (ALUOP_W),
      .MUL_CYCLES (MUL_CYC),
      .DIV_CYCLES (DIV_CYC),
      .SKID_EN    (SKID)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .funct      (funct),
      .rs         (rs),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alucontrol (alucontrol),
      .ri         (ri),
      .hilo_busy  (hilo_busy)
   );

   int         passed = 0;
   int         total = 0;
   int         cyc = 0;
   int         busy_until = -1;
   int         held = 0;
   int         busy_seen = 0;
   logic [8:0] expq[$];
   logic [7:0] fn_tab[int];
   logic [7:0] op_tab[int];

   always @(posedge clk) cyc = cyc + 1;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic build_tables();
      fn_tab[6'b100100] = 8'b00100100;
      fn_tab[6'b100101] = 8'b00100101;
      fn_tab[6'b100110] = 8'b00100110;
      fn_tab[6'b100111] = 8'b00100111;
      fn_tab[6'b000000] = 8'b01111100;
      fn_tab[6'b000010] = 8'b00000010;
      fn_tab[6'b000011] = 8'b00000011;
      fn_tab[6'b000100] = 8'b00000100;
      fn_tab[6'b000110] = 8'b00000110;
      fn_tab[6'b000111] = 8'b00000111;
      fn_tab[6'b010000] = 8'b00010000;
      fn_tab[6'b010001] = 8'b00010001;
      fn_tab[6'b010010] = 8'b00010010;
      fn_tab[6'b010011] = 8'b00010011;
      fn_tab[6'b100000] = 8'b00100000;
      fn_tab[6'b100001] = 8'b00100001;
      fn_tab[6'b100010] = 8'b00100010;
      fn_tab[6'b100011] = 8'b00100011;
      fn_tab[6'b101010] = 8'b00101010;
      fn_tab[6'b101011] = 8'b00101011;
      fn_tab[6'b011000] = 8'b00011000;
      fn_tab[6'b011001] = 8'b00011001;
      fn_tab[6'b011010] = 8'b00011010;
      fn_tab[6'b011011] = 8'b00011011;
      fn_tab[6'b001000] = 8'b00001000;
      fn_tab[6'b001001] = 8'b00001001;
      fn_tab[6'b001100] = 8'b00001100;
      fn_tab[6'b001101] = 8'b00001011;
      op_tab[6'b001100] = 8'b01011001;
      op_tab[6'b001101] = 8'b01011010;
      op_tab[6'b001110] = 8'b01011011;
      op_tab[6'b001111] = 8'b01011100;
      op_tab[6'b001000] = 8'b01010101;
      op_tab[6'b001001] = 8'b01010110;
      op_tab[6'b001010] = 8'b01010111;
      op_tab[6'b001011] = 8'b01011000;
      op_tab[6'b100000] = 8'b11100000;
      op_tab[6'b100100] = 8'b11100100;
      op_tab[6'b100001] = 8'b11100001;
      op_tab[6'b100101] = 8'b11100101;
      op_tab[6'b100011] = 8'b11100011;
      op_tab[6'b101000] = 8'b11101000;
      op_tab[6'b101001] = 8'b11101001;
      op_tab[6'b101011] = 8'b11101011;
   endtask

   // returns {ri, alucontrol}
   function automatic logic [8:0] ref_dec(input logic [5:0] o,
                                          input logic [5:0] f,
                                          input logic [4:0] r);
      if (o == 6'b000000) begin
         if (fn_tab.exists(int'(f))) return {1'b0, fn_tab[int'(f)]};
         return 9'h100;
      end
      if (op_tab.exists(int'(o))) return {1'b0, op_tab[int'(o)]};
      if (o inside {6'b000010, 6'b000011, 6'b000100, 6'b000101,
                    6'b000111, 6'b000110, 6'b000001})
         return 9'h000;
`ifdef ALUDEC_CP0_EN
      if (o == 6'b010000) begin
         if (r == 5'b00100) return {1'b0, 8'b01100000};
         if (r == 5'b00000) return {1'b0, 8'b01011101};
         if (r == 5'b10000 && f == 6'b011000)
            return {1'b0, 8'b01101011};
      end
`else
      if (r == 5'b11111 && o == 6'b111110) return 9'h100;
`endif
      return 9'h100;
   endfunction

   function automatic logic ref_stall(input logic [5:0] o,
                                      input logic [5:0] f,
                                      input logic [4:0] r);
      if (o == 6'b000000)
         return f inside {6'b010000, 6'b010001, 6'b010010, 6'b010011,
                          6'b011000, 6'b011001, 6'b011010, 6'b011011};
`ifdef ALUDEC_CP0_EN
      if (o == 6'b010000 && r == 5'b10000 && f == 6'b011000)
         return 1'b1;
`else
      if (r == 5'b11111 && o == 6'b111110) return 1'b0;
`endif
      return 1'b0;
   endfunction

   // monitor: pops expected entries whenever EX takes one
   logic       hold_prev = 1'b0;
   logic [8:0] prev_out = '0;
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #1;
         held = expq.size();
         chk("out_valid", {31'd0, out_valid}, {31'd0, held != 0});
         if (hold_prev)
            chk("hold_stable", {23'd0, ri, alucontrol}, {23'd0, prev_out});
         hold_prev = out_valid && !out_ready && !flush && !rst;
         prev_out  = {ri, alucontrol};
         if (rst || flush) begin
            expq.delete();
         end else if (out_valid && out_ready && held != 0) begin
            e = expq.pop_front();
            chk("decode", {23'd0, ri, alucontrol}, {23'd0, e});
         end
      end
   end

   task automatic step(input logic v, input logic [5:0] o,
                       input logic [5:0] f, input logic [4:0] r,
                       input logic ordy, input logic fl,
                       input logic rr, output logic acc);
      logic exp_busy, exp_rdy, cap;
      @(negedge clk);
      in_valid  = v;
      op        = o;
      funct     = f;
      rs        = r;
      out_ready = ordy;
      flush     = fl;
      rst       = rr;
      #2;
      exp_busy = (cyc <= busy_until);
      chk("hilo_busy", {31'd0, hilo_busy}, {31'd0, exp_busy});
      if (hilo_busy) busy_seen++;
      cap = (SKID != 0) ? (held < 2) : (held == 0 || ordy);
      exp_rdy = !rr && !fl && cap && !(exp_busy && ref_stall(o, f, r));
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = v && in_ready;
      if (rr) begin
         busy_until = -1;
      end else if (acc) begin
         expq.push_back(ref_dec(o, f, r));
         if (o == 6'b000000 && f inside {6'b011000, 6'b011001})
            busy_until = cyc + MUL_CYC;
         if (o == 6'b000000 && f inside {6'b011010, 6'b011011})
            busy_until = cyc + DIV_CYC;
      end
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, a);
   endtask

   logic [5:0] op_pool[10] = '{6'b000000, 6'b000000, 6'b000000,
                               6'b001001, 6'b100011, 6'b000100,
                               6'b001111, 6'b010000, 6'b000001,
                               6'b101011};
   logic [5:0] fn_pool[8] = '{6'b010000, 6'b010010, 6'b011000,
                              6'b011010, 6'b011011, 6'b100100,
                              6'b000001, 6'b101010};
   logic [4:0] rs_pool[4] = '{5'b00000, 5'b00100, 5'b10000, 5'b00011};

   initial begin
      logic       a;
      logic [5:0] o, f;
      logic [4:0] r;
      build_tables();
      step(0, 0, 0, 0, 0, 0, 1, a);
      step(0, 0, 0, 0, 0, 0, 1, a);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_alucontrol", {24'd0, alucontrol}, 32'd0);
      chk("rst_ri", {31'd0, ri}, 32'd0);
      chk("rst_hilo_busy", {31'd0, hilo_busy}, 32'd0);

      step(1, 6'b000000, 6'b100100, 0, 1, 0, 0, a);
      chk("and_accept", {31'd0, a}, 32'd1);
      idle(2);

      step(1, 6'b100011, 0, 0, 0, 0, 0, a);
      for (int i = 0; i < 3; i++)
         step(1, 6'b000000, 6'b100001, 0, 0, 0, 0, a);
      idle(3);

      busy_seen = 0;
      step(1, 6'b000000, 6'b011010, 0, 1, 0, 0, a);
      chk("div_accept", {31'd0, a}, 32'd1);
      step(1, 6'b001001, 0, 0, 1, 0, 0, a);
      chk("addiu_during_busy", {31'd0, a}, 32'd1);
      a = 1'b0;
      for (int i = 0; i < 100 && !a; i++)
         step(1, 6'b000000, 6'b010000, 0, 1, 0, 0, a);
      chk("mfhi_accept", {31'd0, a}, 32'd1);
      idle(3);
      chk("div_busy_cycles", busy_seen, DIV_CYC);

      step(1, 6'b111111, 0, 0, 1, 0, 0, a);
      step(1, 6'b000000, 6'b000001, 0, 1, 0, 0, a);
      idle(3);

      busy_seen = 0;
      step(1, 6'b000000, 6'b011000, 0, 0, 0, 0, a);
      chk("mult_accept", {31'd0, a}, 32'd1);
      step(0, 0, 0, 0, 1, 1, 0, a);
      idle(4);
      chk("mul_busy_cycles", busy_seen, MUL_CYC);

      step(1, 6'b010000, 0, 5'b00100, 1, 0, 0, a);
      idle(3);

      for (int n = 0; n < 3000; n++) begin
         o = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                         : op_pool[$urandom_range(0, 9)];
         f = ($urandom_range(0, 1) == 0) ? 6'($urandom)
                                         : fn_pool[$urandom_range(0, 7)];
         r = rs_pool[$urandom_range(0, 3)];
         if (o == 6'b010000 && $urandom_range(0, 1) == 0) f = 6'b011000;
         step($urandom_range(0, 3) != 0, o, f, r,
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 299) == 0, a);
      end
      idle(4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
